// File: rtl/mem_axis_tx_seq.sv
// Replays a table of AXI-Stream beats read from a combinational stimulus memory.
// Define MEM_AXIS_TX_SEQ_LOOP_EN to replay the table continuously until gen_stop.
module mem_axis_tx_seq #(
    parameter int DATA_WIDTH = 64,
    parameter int START_ADDR = 0,
    parameter int LAST_ADDR  = 16383
) (
    input  logic                    tx_mac_aclk,
    input  logic                    reset_,
    input  logic                    gen_start,
    input  logic                    gen_stop,
    output logic [31:0]             mem_wr_address,
    input  logic [31:0]             mem_axis_wctrl,
    input  logic [DATA_WIDTH-1:0]   mem_axis_wdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    gen_busy,
    output logic                    gen_done,
    output logic [15:0]             pkt_count
);
    localparam int          KEEP_W  = DATA_WIDTH / 8;
    localparam logic [31:0] START_A = 32'(START_ADDR);
    localparam logic [31:0] LAST_A  = 32'(LAST_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_GAP  = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t                r_state,  w_state_nx;
    logic [31:0]           r_addr,   w_addr_nx;
    logic                  r_eot,    w_eot_nx;
    logic [DATA_WIDTH-1:0] r_tdata,  w_tdata_nx;
    logic [KEEP_W-1:0]     r_tkeep,  w_tkeep_nx;
    logic                  r_tlast,  w_tlast_nx;
    logic                  r_tvalid, w_tvalid_nx;
    logic [7:0]            r_gap,    w_gap_nx;
    logic [15:0]           r_pkt,    w_pkt_nx;
    logic                  r_stop,   w_stop_nx;
    logic                  r_busy,   w_busy_nx;
    logic                  r_done,   w_done_nx;

    logic       w_entry_ok;
    logic [7:0] w_entry_gap;
    logic       w_active;
    logic       w_hs;
    logic       w_stop_now;
    logic       w_ld;
    logic       w_end;
    logic       w_unused_ctrl;

    // r_eot marks that LAST_ADDR was consumed: the next read is end-of-table
    // without ever driving LAST_ADDR+1 onto the memory address.
    assign w_entry_ok    = mem_axis_wctrl[31] & ~r_eot;
    assign w_entry_gap   = mem_axis_wctrl[15:8];
    assign w_active      = (r_state == ST_LOAD) || (r_state == ST_GAP) || (r_state == ST_SEND);
    assign w_hs          = (r_state == ST_SEND) & m_axis_tready;
    assign w_stop_now    = r_stop | gen_stop;
    assign w_unused_ctrl = ^mem_axis_wctrl[30:17];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_eot_nx   = r_eot;
        w_tdata_nx = r_tdata;
        w_tkeep_nx = r_tkeep;
        w_tlast_nx = r_tlast;
        w_gap_nx   = r_gap;
        w_pkt_nx   = r_pkt;
        w_ld       = 1'b0;
        w_end      = 1'b0;
        if (gen_stop && w_active) begin
            w_stop_nx = 1'b1;
        end else begin
            w_stop_nx = r_stop;
        end

        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (gen_start) begin
                    w_state_nx = ST_LOAD;
                    w_addr_nx  = START_A;
                    w_eot_nx   = 1'b0;
                    w_pkt_nx   = 16'd0;
                    w_stop_nx  = 1'b0;
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_LOAD: begin
                if (!w_entry_ok) begin
                    w_end = 1'b1;
                end else begin
                    w_ld       = 1'b1;
                    w_state_nx = (w_entry_gap != 8'd0) ? ST_GAP : ST_SEND;
                end
            end
            ST_GAP: begin
                if (r_gap <= 8'd1) begin
                    w_state_nx = ST_SEND;
                end else begin
                    w_gap_nx = r_gap - 8'd1;
                end
            end
            ST_SEND: begin
                if (w_hs) begin
                    if (r_tlast) begin
                        w_pkt_nx = r_pkt + 16'd1;
                    end else begin
                        w_pkt_nx = r_pkt;
                    end
                    if (r_tlast && w_stop_now) begin
                        w_state_nx = ST_DONE;
                        w_stop_nx  = 1'b0;
                    end else if (w_entry_ok && (w_entry_gap == 8'd0)) begin
                        w_ld = 1'b1;
                    end else begin
                        w_state_nx = ST_LOAD;
                    end
                end else begin
                    w_state_nx = ST_SEND;
                end
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase

        if (w_ld) begin
            w_tdata_nx = mem_axis_wdata;
            w_tkeep_nx = mem_axis_wctrl[KEEP_W-1:0];
            w_tlast_nx = mem_axis_wctrl[16];
            w_gap_nx   = w_entry_gap;
            if (r_addr == LAST_A) begin
                w_eot_nx = 1'b1;
            end else begin
                w_addr_nx = r_addr + 32'd1;
            end
        end else begin
            w_tdata_nx = w_tdata_nx;
        end

        if (w_end) begin
`ifdef MEM_AXIS_TX_SEQ_LOOP_EN
            w_addr_nx  = START_A;
            w_eot_nx   = 1'b0;
            w_state_nx = ST_LOAD;
`else
            w_state_nx = ST_DONE;
            w_stop_nx  = 1'b0;
`endif
        end else begin
            w_state_nx = w_state_nx;
        end

        w_tvalid_nx = (w_state_nx == ST_SEND);
        w_busy_nx   = (w_state_nx == ST_LOAD) || (w_state_nx == ST_GAP) || (w_state_nx == ST_SEND);
        w_done_nx   = (w_state_nx == ST_DONE) && (r_state != ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge tx_mac_aclk or negedge reset_) begin
        if (!reset_) begin
            r_state  <= ST_IDLE;
            r_addr   <= START_A;
            r_eot    <= 1'b0;
            r_tdata  <= {DATA_WIDTH{1'b0}};
            r_tkeep  <= {KEEP_W{1'b0}};
            r_tlast  <= 1'b0;
            r_tvalid <= 1'b0;
            r_gap    <= 8'd0;
            r_pkt    <= 16'd0;
            r_stop   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_addr   <= w_addr_nx;
            r_eot    <= w_eot_nx;
            r_tdata  <= w_tdata_nx;
            r_tkeep  <= w_tkeep_nx;
            r_tlast  <= w_tlast_nx;
            r_tvalid <= w_tvalid_nx;
            r_gap    <= w_gap_nx;
            r_pkt    <= w_pkt_nx;
            r_stop   <= w_stop_nx;
            r_busy   <= w_busy_nx;
            r_done   <= w_done_nx;
        end
    end

    assign mem_wr_address = r_addr;
    assign m_axis_tdata   = r_tdata;
    assign m_axis_tkeep   = r_tkeep;
    assign m_axis_tlast   = r_tlast;
    assign m_axis_tvalid  = r_tvalid;
    assign gen_busy       = r_busy;
    assign gen_done       = r_done;
    assign pkt_count      = r_pkt;

endmodule
